fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port (wr_en / data_in / full) between NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- The arbiter grants one producer at a time and holds the grant for a burst of up to MAX_BURST beats, so short streams stay contiguous in the FIFO.
- Sits directly in front of the shared FIFO; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesting producers (2..8).
- DATA_W, 8, data width per requester and FIFO word width.
- MAX_BURST, 4, maximum beats written per grant before rotation (1..16).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester data-valid.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  per-requester accept; a beat transfers when valid and ready are both high.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_wr_data  output  DATA_W  FIFO write data.
- grant_valid  output  1  high while a grant is held (state BURST).
- grant_id  output  $clog2(NUM_REQ)  index of the granted requester; valid when grant_valid is high.

Behaviour:
- Registered state: fsm (IDLE, BURST), grant_id, last_grant, beat_cnt (width $clog2(MAX_BURST)+1).
- Reset (rst high at posedge) gives:
  - fsm = IDLE, grant_id = 0, last_grant = NUM_REQ-1, beat_cnt = 0.
  - All outputs are 0 during and after reset until a grant is made.
- Reset mid-burst abandons the burst. No write occurs in the reset cycle. Nothing is written to the FIFO from an aborted beat.
- Combinational outputs:
  - xfer = (fsm==BURST) & req_valid[grant_id] & !fifo_full.
  - req_ready[i] = (fsm==BURST) & (grant_id==i) & !fifo_full.
  - fifo_wr_en = xfer.
  - fifo_wr_data = req_data slice for grant_id when xfer is high, else 0.
  - grant_valid = (fsm==BURST).
- IDLE:
  - If any req_valid is high, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Load grant_id with the winner, set beat_cnt = 0, go to BURST.
  - Arbitration latency is 1 cycle: the first write can occur in the cycle after a request is seen in IDLE.
  - If no request is valid, stay in IDLE.
- BURST:
  - On xfer: beat_cnt increments.
  - If beat_cnt == MAX_BURST-1 at that transfer (the burst is complete): set last_grant = grant_id, go to IDLE.
  - If req_valid[grant_id] is low: set last_grant = grant_id, go to IDLE (the grant is released with no write that cycle).
  - If fifo_full is high and req_valid[grant_id] is high: stall. No write, beat_cnt holds, grant held indefinitely.
- Fairness:
  - The released requester becomes lowest priority for the next arbitration.
  - With all requesters continuously valid and the FIFO never full, the grant order is 0,1,2,…,NUM_REQ-1,0,…
  - Each grant writes exactly MAX_BURST beats, followed by one idle arbitration cycle between bursts.
- Non-granted requesters:
  - Their ready is held at 0.
  - Their valid/data may change freely and are ignored.
- FIFO protection:
  - The arbiter never asserts fifo_wr_en while fifo_full is high, so the FIFO never drops a write.
- Wrap-around:
  - The round-robin pointer wraps from NUM_REQ-1 to 0.
  - beat_cnt resets to 0 on every new grant.
- MAX_BURST = 1 degenerates to one beat per grant with strict rotation.

Test Plan:
- Reset: hold rst for 2 cycles with all req_valid=1 → fifo_wr_en=0, req_ready=0, grant_valid=0 throughout. After rst falls, the first grant goes to requester 0.
- Single requester: req_valid=4'b0100, data 0x10..0x15 (6 beats), MAX_BURST=4, fifo_full=0 → writes 0x10–0x13, one idle cycle, grant_id=2 again, then writes 0x14–0x15.
- All four valid continuously, fifo_full=0, 32 cycles → grant sequence 0,1,2,3,0,… Each grant writes 4 consecutive beats. Exactly 1 gap cycle between bursts.
- Back-pressure: requester 1 granted; fifo_full rises after beat 2 for 5 cycles → fifo_wr_en=0 and req_ready[1]=0 for those 5 cycles; grant_id stays 1. Beats 3–4 are written after full drops, then rotation.
- Early release: requester 3 granted, drops valid after 1 beat while requester 0 is valid → grant_valid falls, next grant goes to 0, last_grant=3.
- Reset mid-burst: assert rst during beat 2 of a burst to requester 2 → no write in the reset cycle. After reset the arbiter restarts at requester 0 priority, and no duplicate or stray write appears.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter_if
// Description : Producer handshakes and shared FIFO write port seen by the
//               round-robin write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int c_ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_wr_data;
    logic                      grant_valid;
    logic [c_ID_W-1:0]         grant_id;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NUM_REQ valid/ready producers.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.master  bus
);
    localparam int                 c_ID_W      = $clog2(NUM_REQ);
    localparam int                 c_CNT_W     = $clog2(MAX_BURST) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);
    localparam logic [c_ID_W-1:0]  c_LAST_ID   = c_ID_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_ID_W-1:0]   r_grant_id, w_grant_id_nxt;
    logic [c_ID_W-1:0]   r_last_grant, w_last_grant_nxt;
    logic [c_CNT_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
    logic [c_ID_W-1:0]   w_winner;
    logic                w_found;
    logic                w_in_burst;
    logic                w_sel_valid;
    logic                w_xfer;
    logic [NUM_REQ-1:0]  w_ready;
    logic [DATA_W-1:0]   w_lane [NUM_REQ];
    int                  w_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign w_lane[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    // First valid requester after the last one served, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_found && bus.req_valid[c_ID_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = c_ID_W'(w_idx);
            end
        end
    end

    // Reset gates every output so an in-flight beat is never written.
    assign w_in_burst  = (r_state == ST_BURST) && !rst;
    assign w_sel_valid = bus.req_valid[r_grant_id];
    assign w_xfer      = w_in_burst && w_sel_valid && !bus.fifo_full;

    always_comb begin
        w_ready = '0;
        if (w_in_burst && !bus.fifo_full) begin
            w_ready[r_grant_id] = 1'b1;
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.fifo_wr_en   = w_xfer;
    assign bus.fifo_wr_data = w_xfer ? w_lane[r_grant_id] : '0;
    assign bus.grant_valid  = w_in_burst;
    assign bus.grant_id     = rst ? '0 : r_grant_id;

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_id_nxt   = r_grant_id;
        w_last_grant_nxt = r_last_grant;
        w_beat_cnt_nxt   = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = ST_BURST;
                    w_grant_id_nxt = w_winner;
                    w_beat_cnt_nxt = '0;
                end
            end
            ST_BURST: begin
                if (!w_sel_valid) begin
                    w_last_grant_nxt = r_grant_id;
                    w_state_nxt      = ST_IDLE;
                end else if (!bus.fifo_full) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    if (r_beat_cnt == c_LAST_BEAT) begin
                        w_last_grant_nxt = r_grant_id;
                        w_state_nxt      = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= c_LAST_ID;
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed bench for fifo_wr_arbiter with a burst-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;
    localparam int c_N  = 4;
    localparam int c_DW = 8;
    localparam int c_MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [c_N-1:0]      tb_valid = '0;
    logic [c_N*c_DW-1:0] tb_data  = '0;
    logic                tb_full  = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(c_N), .DATA_W(c_DW)) bus ();

    assign bus.req_valid = tb_valid;
    assign bus.req_data  = tb_data;
    assign bus.fifo_full = tb_full;

    fifo_wr_arbiter #(.NUM_REQ(c_N), .DATA_W(c_DW), .MAX_BURST(c_MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Producer streams
    logic [7:0] pdata [c_N][32];
    int phead [c_N];
    int ptail [c_N];

    // Log of observed FIFO writes
    int log_d [256];
    int log_c [256];
    int log_s [256];
    int log_n = 0;
    int cyc_n = 0;

    // Burst-level model: who owns the port, beats written, last served.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = c_N - 1;
    bit m_fresh = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int r, input logic [7:0] v);
        pdata[r][ptail[r]] = v;
        ptail[r]++;
    endtask

    task automatic wait_writes(input int n);
        int c = 0;
        while (log_n < n && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (log_n < n) begin
            total++;
            bad++;
            $display("FAIL wait_writes actual=%0d required=%0d time=%0t", log_n, n, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < c_N; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
            for (int k = 0; k < 32; k++) pdata[i][k] = '0;
        end
    end

    // Producers present the head of their stream just after each rising edge.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < c_N; i++) begin
            tb_valid[i]                = (phead[i] < ptail[i]);
            tb_data[i*c_DW +: c_DW]    = pdata[i][phead[i] % 32];
        end
    end

    // Compare process: inputs are stable at the falling edge and equal those
    // the DUT will sample at the next rising edge.
    always @(negedge clk) begin
        logic [c_N-1:0]  e_ready;
        logic            e_we;
        logic [c_DW-1:0] e_data;
        int              idx;
        cyc_n++;
        if (rst) begin
            chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
            chk("rst_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_gvalid", 32'(bus.grant_valid), 32'd0);
            chk("rst_gid", 32'(bus.grant_id), 32'd0);
            chk("rst_wdata", 32'(bus.fifo_wr_data), 32'd0);
            m_owner = -1;
            m_beats = 0;
            m_last  = c_N - 1;
            m_fresh = 1'b1;
        end else begin
            e_ready = '0;
            e_we    = 1'b0;
            e_data  = '0;
            if (m_owner >= 0) begin
                if (!tb_full) e_ready[m_owner] = 1'b1;
                e_we = tb_valid[m_owner] && !tb_full;
                if (e_we) e_data = tb_data[m_owner*c_DW +: c_DW];
            end
            chk("gvalid", 32'(bus.grant_valid), 32'(m_owner >= 0));
            chk("ready", 32'(bus.req_ready), 32'(e_ready));
            chk("wr_en", 32'(bus.fifo_wr_en), 32'(e_we));
            chk("wr_data", 32'(bus.fifo_wr_data), 32'(e_data));
            if (m_owner >= 0) chk("gid", 32'(bus.grant_id), 32'(m_owner));
            else if (m_fresh) chk("gid_fresh", 32'(bus.grant_id), 32'd0);

            if (m_owner < 0) begin
                for (int k = 1; k <= c_N; k++) begin
                    idx = (m_last + k) % c_N;
                    if (m_owner < 0 && tb_valid[idx]) begin
                        m_owner = idx;
                        m_beats = 0;
                        m_fresh = 1'b0;
                    end
                end
            end else if (!tb_valid[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (!tb_full) begin
                m_beats++;
                if (m_beats == c_MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end

        if (bus.fifo_wr_en && log_n < 256) begin
            log_d[log_n] = int'(bus.fifo_wr_data);
            log_c[log_n] = cyc_n;
            log_s[log_n] = int'(bus.grant_id);
            log_n++;
        end
        for (int i = 0; i < c_N; i++) begin
            if (tb_valid[i] && bus.req_ready[i]) phead[i]++;
        end
    end

    initial begin
        int base;

        // Reset held two cycles with every producer valid, then a full
        // round-robin sweep of eight bursts.
        for (int i = 0; i < c_N; i++)
            for (int k = 0; k < 8; k++) load(i, 8'(i*16 + k));
        @(posedge clk);
        @(negedge clk);
        chk("reset_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("reset_gvalid", 32'(bus.grant_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_writes(32);
        for (int n = 0; n < 32; n++) begin
            chk("rr_data", 32'(log_d[n]), 32'(((n/4)%4)*16 + (n/16)*4 + n%4));
            chk("rr_src", 32'(log_s[n]), 32'((n/4)%4));
            if (n > 0) chk("rr_gap", 32'(log_c[n] - log_c[n-1]), (n%4 == 0) ? 32'd2 : 32'd1);
        end

        // Single requester longer than one burst.
        base = log_n;
        for (int k = 0; k < 6; k++) load(2, 8'(8'h10 + k));
        wait_writes(base + 6);
        for (int n = 0; n < 6; n++) begin
            chk("single_data", 32'(log_d[base+n]), 32'(8'h10 + n));
            chk("single_src", 32'(log_s[base+n]), 32'd2);
        end
        chk("single_gap", 32'(log_c[base+4] - log_c[base+3]), 32'd2);

        // Back-pressure after beat 2 of a burst to requester 1.
        base = log_n;
        for (int k = 0; k < 4; k++) load(1, 8'(8'h20 + k));
        wait_writes(base + 2);
        tb_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_wr_en", 32'(bus.fifo_wr_en), 32'd0);
            chk("bp_ready1", 32'(bus.req_ready[1]), 32'd0);
            chk("bp_gid", 32'(bus.grant_id), 32'd1);
            @(posedge clk);
        end
        #1 tb_full = 1'b0;
        wait_writes(base + 4);
        for (int n = 0; n < 4; n++) chk("bp_data", 32'(log_d[base+n]), 32'(8'h20 + n));
        chk("bp_gap", 32'(log_c[base+2] - log_c[base+1]), 32'd6);

        // Early release by requester 3 while requester 0 waits.
        base = log_n;
        load(3, 8'h30);
        load(0, 8'h40);
        load(0, 8'h41);
        wait_writes(base + 1);
        load(2, 8'h50);
        @(negedge clk);
        chk("er_release_wr", 32'(bus.fifo_wr_en), 32'd0);
        @(negedge clk);
        chk("er_gvalid", 32'(bus.grant_valid), 32'd0);
        wait_writes(base + 4);
        chk("er_d0", 32'(log_d[base]),   32'h30);
        chk("er_d1", 32'(log_d[base+1]), 32'h40);
        chk("er_d2", 32'(log_d[base+2]), 32'h41);
        chk("er_d3", 32'(log_d[base+3]), 32'h50);
        chk("er_gap", 32'(log_c[base+1] - log_c[base]), 32'd3);

        // Reset during beat 2 of a burst to requester 2.
        base = log_n;
        for (int k = 0; k < 4; k++) load(2, 8'(8'h60 + k));
        wait_writes(base + 1);
        rst = 1'b1;
        load(0, 8'h70);
        load(0, 8'h71);
        @(negedge clk);
        chk("mr_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        chk("mr_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_writes(base + 6);
        chk("mr_d0", 32'(log_d[base]),   32'h60);
        chk("mr_d1", 32'(log_d[base+1]), 32'h70);
        chk("mr_d2", 32'(log_d[base+2]), 32'h71);
        chk("mr_d3", 32'(log_d[base+3]), 32'h61);
        chk("mr_d4", 32'(log_d[base+4]), 32'h62);
        chk("mr_d5", 32'(log_d[base+5]), 32'h63);
        chk("mr_src1", 32'(log_s[base+1]), 32'd0);

        repeat (10) @(posedge clk);
        chk("total_writes", 32'(log_n), 32'(base + 6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
